cpu_control_unit: RTL
=====================

// Module: cpu_control_unit
// PURPOSE
//  Multicycle control FSM for the CPU datapath; replaces the bench-driven control signals.
//  Decodes opcode and status_reg, and sequences fetch/decode/execute/writeback.
//  Adds a memory ready handshake, a bounded wait timeout, halt/illegal detection and a retired-instruction counter.
// PARAMETERS
//  OPCODE_SIZE  5   opcode width (IR[15:11])
//  WORD_SIZE    16  status_reg width
//  Z_BIT        0   status_reg bit index of zero flag
//  WAIT_LIMIT   15  max cycles waiting on mem_ready before error; 0 = wait forever
//  CNT_WIDTH    16  retired counter width
// PORTS
//  clk               in   1            rising-edge clock
//  rst               in   1            synchronous, active-high reset
//  opcode            in   OPCODE_SIZE  from IR
//  status_reg        in   WORD_SIZE    ALU flags
//  mem_ready         in   1            memory completes the current read/write this cycle
//  ALU_in2_mux       out  1            0=immediate, 1=reg_buff2
//  mem_out_mux       out  1            0=reg_buff1, 1=PC (store data source)
//  PC_mux            out  2            0=PC+1, 1=immediate target, 2=ALU_out
//  memory_addr_mux   out  2            0=PC, 1=immediate, 2=ALU_out
//  data_in_mux       out  2            0=ALU_out, 1=memory_out, 2=immediate
//  reg_buff1_write, reg_buff2_write, status_reg_write, ALU_out_write, reg_write, PC_write, IR_write  out 1 each
//  mem_read, mem_write  out  1         memory request strobes
//  halted            out  1            sticky; set in HALT
//  error             out  1            sticky; illegal opcode or mem timeout
//  retired           out  CNT_WIDTH    count of completed instructions
// BEHAVIOUR
//  Decode: 0xxxx ALU (op[3]=1 immediate operand, op[2:0]=ALU op); 11100 LOAD; 11101 STORE;
//   11110 LOAD_I; 11000 JMP; 11001 BRZ; 11111 HALT; any other = illegal.
//  States: FETCH, DECODE, EXEC, ALU_WB, MEM_RD, MEM_WB, MEM_WR, LOADI, JUMP, HALT.
//  Outputs are decoded from the state register.
//   Exception: FETCH/MEM_RD/MEM_WR write enables are also gated by mem_ready.
//  Every enable and strobe not listed for a state is 0. Every mux not listed is 0.
//  FETCH:  mem_read=1, addr_mux=0.
//          If mem_ready: IR_write=1, PC_write=1 (PC_mux=0), then go to DECODE. Else stay.
//  DECODE: reg_buff1_write=reg_buff2_write=1.
//          Next state: ALU->EXEC; LOAD->MEM_RD; STORE->MEM_WR; LOAD_I->LOADI; JMP/BRZ->JUMP;
//          HALT or illegal->HALT (illegal also sets error).
//  EXEC:   ALU_in2_mux=~op[3], ALU_out_write=1, status_reg_write=1 -> ALU_WB.
//  ALU_WB: reg_write=1, data_in_mux=0 -> FETCH; retire.
//  MEM_RD: mem_read=1, addr_mux=1. If mem_ready -> MEM_WB.
//  MEM_WB: data_in_mux=1, reg_write=1 -> FETCH; retire.
//  MEM_WR: mem_write=1, addr_mux=1, mem_out_mux=0. If mem_ready -> FETCH; retire.
//  LOADI:  data_in_mux=2, reg_write=1 -> FETCH; retire.
//  JUMP:   PC_mux=1. PC_write=1 for JMP, or for BRZ when status_reg[Z_BIT]=1 -> FETCH; retire.
//          BRZ not taken still retires.
//  HALT:   all enables 0; halted=1; stays until rst.
//  Timeout: wait counter clears on entry to FETCH/MEM_RD/MEM_WR and on mem_ready.
//   It increments each cycle spent waiting.
//   When WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT with mem_ready low:
//   error=1 and go to HALT; no strobes are issued in that cycle.
//  retired: +1 on the cycle leaving a retiring state. Wraps modulo 2^CNT_WIDTH. Not incremented for HALT/illegal.
//  Reset: state=FETCH, wait counter=0, retired=0, halted=0, error=0.
//   Outputs after reset: mem_read=1, all others 0.
//   rst has priority over everything. Reset mid-wait drops the pending request immediately.
//  Latency (mem_ready tied 1): ALU 4 cycles, LOAD_I 3, LOAD 4, STORE 3, JMP/BRZ 3.
// TESTING
//  1. mem_ready=1, opcode=11110 -> FETCH(IR_write,PC_write), DECODE, LOADI(data_in_mux=2,reg_write); retired=1.
//  2. opcode=00000 -> EXEC with ALU_in2_mux=1, ALU_out_write, status_reg_write.
//     Then ALU_WB with reg_write, data_in_mux=0; 4 cycles total.
//  3. STORE with mem_ready low 3 cycles -> mem_write held 3 cycles, no enables; completes on 4th; retired +1.
//  4. BRZ with status_reg[0]=0 -> no PC_write in JUMP; with 1 -> PC_write=1, PC_mux=1.
//  5. WAIT_LIMIT=4, mem_ready stuck 0 in FETCH -> error=1, halted=1 after 4 wait cycles.
//     Opcode 10101 -> error=1, halted=1.
//  6. Assert rst during MEM_RD wait -> next cycle FETCH, mem_read=1, retired=0, error=0.

Source files
------------

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control_unit
//  Purpose  : Multicycle control FSM sequencing fetch/decode/execute/writeback,
//             with memory-ready handshake, bounded wait timeout, halt/illegal
//             detection and a retired-instruction counter.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
    parameter int OPCODE_SIZE = 5,
    parameter int WORD_SIZE   = 16,
    parameter int Z_BIT       = 0,
    parameter int WAIT_LIMIT  = 15,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic [WORD_SIZE-1:0]   status_reg,
    input  logic                   mem_ready,
    output logic                   ALU_in2_mux,
    output logic                   mem_out_mux,
    output logic [1:0]             PC_mux,
    output logic [1:0]             memory_addr_mux,
    output logic [1:0]             data_in_mux,
    output logic                   reg_buff1_write,
    output logic                   reg_buff2_write,
    output logic                   status_reg_write,
    output logic                   ALU_out_write,
    output logic                   reg_write,
    output logic                   PC_write,
    output logic                   IR_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   halted,
    output logic                   error,
    output logic [CNT_WIDTH-1:0]   retired
);

    localparam logic [OPCODE_SIZE-1:0] c_op_load  = OPCODE_SIZE'(5'b11100);
    localparam logic [OPCODE_SIZE-1:0] c_op_store = OPCODE_SIZE'(5'b11101);
    localparam logic [OPCODE_SIZE-1:0] c_op_loadi = OPCODE_SIZE'(5'b11110);
    localparam logic [OPCODE_SIZE-1:0] c_op_jmp   = OPCODE_SIZE'(5'b11000);
    localparam logic [OPCODE_SIZE-1:0] c_op_brz   = OPCODE_SIZE'(5'b11001);
    localparam logic [OPCODE_SIZE-1:0] c_op_halt  = OPCODE_SIZE'(5'b11111);

    // Wait counter only needs to reach WAIT_LIMIT; it saturates when the limit is 0.
    localparam int                   c_wcw      = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [c_wcw-1:0]     c_wait_max = c_wcw'(WAIT_LIMIT);
    localparam logic [c_wcw-1:0]     c_wait_one = c_wcw'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALU_WB = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WB = 4'd5,
        S_MEM_WR = 4'd6,
        S_LOADI  = 4'd7,
        S_JUMP   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t               state_q, state_d;
    logic [c_wcw-1:0]     wait_q, wait_d;
    logic [CNT_WIDTH-1:0] retired_q;
    logic                 error_q;

    logic w_is_alu, w_is_jmp, w_is_brz;
    logic w_waiting, w_timeout, w_retire, w_set_err;
    logic unused_status;

    // Only the zero flag steers control; the other flags are deliberately ignored.
    assign unused_status = ^status_reg;

    assign w_is_alu  = ~opcode[OPCODE_SIZE-1];
    assign w_is_jmp  = (opcode == c_op_jmp);
    assign w_is_brz  = (opcode == c_op_brz);
    assign w_waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign w_timeout = w_waiting && !mem_ready && (WAIT_LIMIT != 0) && (wait_q == c_wait_max);

    // Next state, retire and error-set decisions for the current state.
    always_comb begin
        state_d   = state_q;
        w_retire  = 1'b0;
        w_set_err = 1'b0;
        if (w_timeout) begin
            state_d   = S_HALT;
            w_set_err = 1'b1;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_d = S_DECODE;
                S_DECODE: begin
                    if (w_is_alu)                 state_d = S_EXEC;
                    else if (opcode == c_op_load)  state_d = S_MEM_RD;
                    else if (opcode == c_op_store) state_d = S_MEM_WR;
                    else if (opcode == c_op_loadi) state_d = S_LOADI;
                    else if (w_is_jmp || w_is_brz) state_d = S_JUMP;
                    else begin
                        state_d   = S_HALT;
                        w_set_err = (opcode != c_op_halt);
                    end
                end
                S_EXEC:   state_d = S_ALU_WB;
                S_MEM_RD: if (mem_ready) state_d = S_MEM_WB;
                S_MEM_WR: if (mem_ready) begin
                    state_d  = S_FETCH;
                    w_retire = 1'b1;
                end
                S_ALU_WB, S_MEM_WB, S_LOADI, S_JUMP: begin
                    state_d  = S_FETCH;
                    w_retire = 1'b1;
                end
                S_HALT:   state_d = S_HALT;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    // Wait counter: counts cycles stalled on mem_ready, cleared everywhere else.
    always_comb begin
        wait_d = '0;
        if (w_waiting && !mem_ready && !w_timeout && (wait_q != {c_wcw{1'b1}}))
            wait_d = wait_q + c_wait_one;
    end

    // Control outputs decoded from the state; request-state enables follow mem_ready.
    always_comb begin
        ALU_in2_mux      = 1'b0;
        mem_out_mux      = 1'b0;
        PC_mux           = 2'd0;
        memory_addr_mux  = 2'd0;
        data_in_mux      = 2'd0;
        reg_buff1_write  = 1'b0;
        reg_buff2_write  = 1'b0;
        status_reg_write = 1'b0;
        ALU_out_write    = 1'b0;
        reg_write        = 1'b0;
        PC_write         = 1'b0;
        IR_write         = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        halted           = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = ~w_timeout;
                IR_write = mem_ready;
                PC_write = mem_ready;
            end
            S_DECODE: begin
                reg_buff1_write = 1'b1;
                reg_buff2_write = 1'b1;
            end
            S_EXEC: begin
                ALU_in2_mux      = ~opcode[3];
                ALU_out_write    = 1'b1;
                status_reg_write = 1'b1;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_MEM_RD: begin
                memory_addr_mux = 2'd1;
                mem_read        = ~w_timeout;
            end
            S_MEM_WB: begin
                data_in_mux = 2'd1;
                reg_write   = 1'b1;
            end
            S_MEM_WR: begin
                memory_addr_mux = 2'd1;
                mem_write       = ~w_timeout;
            end
            S_LOADI: begin
                data_in_mux = 2'd2;
                reg_write   = 1'b1;
            end
            S_JUMP: begin
                PC_mux   = 2'd1;
                PC_write = w_is_jmp | (w_is_brz & status_reg[Z_BIT]);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // State, wait counter, retired counter and sticky error; reset wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (w_retire)
                retired_q <= retired_q + c_cnt_one;
            if (w_set_err)
                error_q <= 1'b1;
        end
    end

    assign retired = retired_q;
    assign error   = error_q;

endmodule
`default_nettype wire
